// File: rtl/b_channel.sv
// b_channel: in-order pending-write table for the AXI write-response path, with
// write completion pulses, full/empty throttling, read-after-write hazard detection and a sticky error flag.
module b_channel #(
  parameter int          DEPTH  = 4,
  parameter logic [3:0]  WR_ID  = 4'd1,
  parameter int          ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              aw_fire,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic [3:0]        bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic              wr_data_ok,
  output logic              wr_full,
  output logic              wr_empty,
  input  logic [ADDR_W-1:0] rd_check_addr,
  output logic              raw_hazard,
  output logic              bus_err
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-3:0] addr_q [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       cnt_q;
  logic              ok_q, err_q;
  logic              b_fire, push, drop, b_bad, hz;
  assign bready     = cnt_q != '0;
  assign wr_empty   = ~bready;
  assign wr_full    = cnt_q == (PW+1)'(DEPTH);
  assign b_fire     = bvalid & bready;
  // a pop in the same cycle frees the slot a full-table push needs
  assign push       = aw_fire & (~wr_full | b_fire);
  assign drop       = aw_fire & ~push;
  assign b_bad      = b_fire & ((bresp != 2'b00) | (bid != WR_ID));
  assign wr_data_ok = ok_q;
  assign bus_err    = err_q;
  assign raw_hazard = hz;
  always_comb begin
    vld_d = vld_q;
    if (b_fire) vld_d[rd_ptr_q] = 1'b0;
    if (push) vld_d[wr_ptr_q] = 1'b1;
  end
  always_comb begin
    hz = aw_fire & (aw_addr[ADDR_W-1:2] == rd_check_addr[ADDR_W-1:2]);
    for (int i = 0; i < DEPTH; i++)
      hz = hz | (vld_q[i] & (addr_q[i] == rd_check_addr[ADDR_W-1:2]));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_q + PW'(push);
      rd_ptr_q <= rd_ptr_q + PW'(b_fire);
      cnt_q    <= cnt_q + (PW+1)'(push) - (PW+1)'(b_fire);
      ok_q     <= b_fire;
      err_q    <= err_q | drop | b_bad;
    end
  end
  always_ff @(posedge clk)
    if (push) addr_q[wr_ptr_q] <= aw_addr[ADDR_W-1:2];
endmodule

// File: tb/tb_b_channel.sv
// tb_b_channel: directed literal checks plus randomized traffic compared every
// cycle against a queue-based model of the pending-write table.
module tb_b_channel;
  localparam int DEPTH = 4;
  localparam int ADDR_W = 32;
  logic clk = 0, reset = 1, aw_fire = 0, bvalid = 0;
  logic [ADDR_W-1:0] aw_addr = '0, rd_check_addr = '0;
  logic [3:0] bid = 4'd1;
  logic [1:0] bresp = 2'b00;
  logic bready, wr_data_ok, wr_full, wr_empty, raw_hazard, bus_err;
  int errors = 0, checks = 0;
  b_channel #(.DEPTH(DEPTH), .WR_ID(4'd1), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .aw_fire(aw_fire), .aw_addr(aw_addr), .bid(bid),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .wr_data_ok(wr_data_ok),
    .wr_full(wr_full), .wr_empty(wr_empty), .rd_check_addr(rd_check_addr),
    .raw_hazard(raw_hazard), .bus_err(bus_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask
  // model: pending word addresses in issue order, plus pulse and sticky error
  logic [ADDR_W-3:0] q[$];
  logic m_ok = 0, m_err = 0, m_init = 0;
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_ok <= 0;
      m_err <= 0;
      m_init <= 1;
    end else begin
      logic fire;
      fire = bvalid && q.size() > 0;
      if (fire) begin
        if (bresp != 2'b00 || bid != 4'd1) m_err <= 1;
        void'(q.pop_front());
      end
      m_ok <= fire;
      if (aw_fire) begin
        if (q.size() < DEPTH) q.push_back(aw_addr[ADDR_W-1:2]);
        else m_err <= 1;
      end
    end
  end
  always @(negedge clk) begin
    if (m_init && !reset) begin
      logic h;
      h = aw_fire && aw_addr[ADDR_W-1:2] == rd_check_addr[ADDR_W-1:2];
      foreach (q[i]) if (q[i] == rd_check_addr[ADDR_W-1:2]) h = 1;
      chk("m_bready", bready, q.size() != 0);
      chk("m_full", wr_full, q.size() == DEPTH);
      chk("m_empty", wr_empty, q.size() == 0);
      chk("m_data_ok", wr_data_ok, m_ok);
      chk("m_bus_err", bus_err, m_err);
      chk("m_hazard", raw_hazard, h);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1; aw_fire = 0; bvalid = 0; bid = 4'd1; bresp = 2'b00;
    tick();
    reset = 0;
  endtask
  task automatic push(input logic [ADDR_W-1:0] a);
    aw_fire = 1; aw_addr = a;
    tick();
    aw_fire = 0;
  endtask
  initial begin
    do_reset();
    #1;
    chk("rst_empty", wr_empty, 1'b1);
    chk("rst_bready", bready, 1'b0);
    chk("rst_full", wr_full, 1'b0);
    chk("rst_ok", wr_data_ok, 1'b0);
    chk("rst_err", bus_err, 1'b0);
    push(32'h1000_0004);
    #1 chk("single_bready", bready, 1'b1);
    tick();
    bvalid = 1;
    tick();
    bvalid = 0;
    #1 chk("single_ok", wr_data_ok, 1'b1);
    chk("single_empty", wr_empty, 1'b1);
    tick();
    chk("single_ok_drop", wr_data_ok, 1'b0);
    push(32'h2000_0008);
    rd_check_addr = 32'h2000_000B;
    #1 chk("hz_same_word", raw_hazard, 1'b1);
    rd_check_addr = 32'h2000_000C;
    #1 chk("hz_other_word", raw_hazard, 1'b0);
    aw_fire = 1; aw_addr = 32'h2000_000C;
    #1 chk("hz_forward", raw_hazard, 1'b1);
    tick();
    aw_fire = 0; bvalid = 1;
    tick();
    #1 chk("hz_still_pending", raw_hazard, 1'b1);
    tick();
    bvalid = 0;
    #1 chk("hz_cleared", raw_hazard, 1'b0);
    tick();
    push(32'h0); push(32'h4); push(32'h8); push(32'hC);
    #1 chk("fill_full", wr_full, 1'b1);
    aw_fire = 1; aw_addr = 32'h10; bvalid = 1;
    tick();
    aw_fire = 0;
    #1 chk("wrap_full", wr_full, 1'b1);
    chk("wrap_ok", wr_data_ok, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_ok", wr_data_ok, 1'b1);
    end
    bvalid = 0;
    tick();
    chk("drain_ok_end", wr_data_ok, 1'b0);
    chk("drain_empty", wr_empty, 1'b1);
    chk("no_err_yet", bus_err, 1'b0);
    push(32'h0); push(32'h4); push(32'h8); push(32'hC);
    push(32'h10);
    #1 chk("overflow_err", bus_err, 1'b1);
    chk("overflow_full", wr_full, 1'b1);
    do_reset();
    push(32'h40);
    bvalid = 1; bresp = 2'b10;
    tick();
    bvalid = 0; bresp = 2'b00;
    #1 chk("bresp_ok", wr_data_ok, 1'b1);
    chk("bresp_err", bus_err, 1'b1);
    chk("bresp_empty", wr_empty, 1'b1);
    tick(); tick();
    chk("err_sticky", bus_err, 1'b1);
    do_reset();
    push(32'h44);
    bvalid = 1; bid = 4'd2;
    tick();
    bvalid = 0; bid = 4'd1;
    #1 chk("bid_err", bus_err, 1'b1);
    do_reset();
    bvalid = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("emptyb_bready", bready, 1'b0);
      chk("emptyb_ok", wr_data_ok, 1'b0);
    end
    bvalid = 0;
    chk("emptyb_empty", wr_empty, 1'b1);
    push(32'h30); push(32'h34); push(32'h38);
    do_reset();
    rd_check_addr = 32'h34;
    #1 chk("midrst_empty", wr_empty, 1'b1);
    chk("midrst_bready", bready, 1'b0);
    chk("midrst_ok", wr_data_ok, 1'b0);
    chk("midrst_hazard", raw_hazard, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      aw_fire = $urandom_range(0, 1);
      aw_addr = {26'h0, 4'($urandom_range(0, 7)), 2'($urandom)};
      rd_check_addr = {26'h0, 4'($urandom_range(0, 7)), 2'($urandom)};
      bvalid = $urandom_range(0, 2) != 0;
      bid = ($urandom_range(0, 39) == 0) ? 4'd3 : 4'd1;
      bresp = ($urandom_range(0, 39) == 0) ? 2'b10 : 2'b00;
      tick();
    end
    reset = 0; aw_fire = 0; bvalid = 0;
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
